// File: rtl/core_timer_axi_slave_pkg.sv
// Shared constants and types for the core timer AXI4-Lite slave: data width,
// timer register addresses, response codes and FSM state encoding.
package core_timer_axi_slave_pkg;

  localparam int          AXI_DATA_WIDTH = 32;
  localparam logic [31:0] MTIMECMP_ADDR  = 32'h0000_4000;
  localparam logic [31:0] MTIME_ADDR     = 32'h0000_BFF8;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_RESP
  } axi_state_e;

  // Only aligned, full-word writes reach the timer registers.
  function automatic logic wr_is_err(input logic [1:0] lsb, input logic [3:0] strb);
    return (lsb != 2'b00) || (strb != 4'hF);
  endfunction

endpackage

// File: rtl/core_timer_axi_slave.sv
// AXI4-Lite slave fronting the core timer registers: one transaction in flight,
// single-cycle register strobes, round-robin read/write arbitration.
module core_timer_axi_slave
  import core_timer_axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [31:0]               AWADDR,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [AXI_DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]                WSTRB,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [1:0]                BRESP,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  input  logic [31:0]               ARADDR,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      valid_reg_write,
  output logic                      valid_reg_read,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic [AXI_DATA_WIDTH-1:0] write_data,
  input  logic [AXI_DATA_WIDTH-1:0] read_data,
  input  logic                      read_data_valid
);

  axi_state_e                state_q, state_d;
  logic                      aw_held_q, w_held_q;
  logic                      last_grant_q;   // 1: last accepted transaction was a write
  logic                      grant_rd_q, grant_rd_d;
  logic [31:0]               addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [3:0]                wstrb_q;
  logic [1:0]                bresp_q, rresp_q;
  logic                      idle, held_any, aw_fire, w_fire, ar_fire, wr_go;
  logic                      wr_err, rd_err, unused_addr_bits;

  assign idle     = (state_q == ST_IDLE);
  assign held_any = aw_held_q | w_held_q;

  // Readies come from registered state only; the grant bit is itself a flop.
  assign AWREADY = !ARESET && idle && !aw_held_q && (held_any || !grant_rd_q);
  assign WREADY  = !ARESET && idle && !w_held_q  && (held_any || !grant_rd_q);
  assign ARREADY = !ARESET && idle && !held_any  && grant_rd_q;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID  && WREADY;
  assign ar_fire = ARVALID && ARREADY;
  assign wr_go   = (aw_held_q || aw_fire) && (w_held_q || w_fire);

  assign wr_err = wr_is_err(addr_q[1:0], wstrb_q);
  assign rd_err = (addr_q[1:0] != 2'b00);

  assign BVALID     = (state_q == ST_WR_RESP);
  assign RVALID     = (state_q == ST_RD_RESP);
  assign BRESP      = bresp_q;
  assign RRESP      = rresp_q;
  assign RDATA      = rdata_q;
  assign addr       = addr_q[ADDR_WIDTH-1:0];
  assign write_data = wdata_q;

  // Upper address bits are latched but intentionally never decoded.
  assign unused_addr_bits = ^addr_q;

  always_comb begin
    state_d         = state_q;
    valid_reg_write = 1'b0;
    valid_reg_read  = 1'b0;
    grant_rd_d      = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_go)        state_d = ST_WR_ISSUE;
        else if (ar_fire) state_d = ST_RD_ISSUE;
        // Steer the grant toward whichever side is requesting alone.
        if (!held_any) begin
          if (ARVALID && !(AWVALID || WVALID))      grant_rd_d = 1'b1;
          else if (!ARVALID && (AWVALID || WVALID)) grant_rd_d = 1'b0;
        end
      end
      ST_WR_ISSUE: begin
        valid_reg_write = !wr_err;
        state_d         = ST_WR_RESP;
      end
      ST_WR_RESP:  if (BREADY) state_d = ST_IDLE;
      ST_RD_ISSUE: begin
        valid_reg_read = !rd_err;
        state_d        = ST_RD_RESP;
      end
      ST_RD_RESP:  if (RREADY) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      last_grant_q <= 1'b0;
      grant_rd_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      grant_rd_q <= grant_rd_d;
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        addr_q    <= AWADDR;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= WDATA;
        wstrb_q  <= WSTRB;
      end
      if (ar_fire) addr_q <= ARADDR;
      if (aw_fire || w_fire) last_grant_q <= 1'b1;
      else if (ar_fire)      last_grant_q <= 1'b0;
      if (BVALID && BREADY) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (state_q == ST_WR_ISSUE) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (state_q == ST_RD_ISSUE) begin
        rresp_q <= (rd_err || !read_data_valid) ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= (rd_err || !read_data_valid) ? '0 : read_data;
      end
    end
  end

endmodule

// File: tb/tb_core_timer_axi_slave.sv
// Directed bench for core_timer_axi_slave: expected strobes and responses are
// queued at stimulus time and checked by a monitor when the DUT produces them.
module tb_core_timer_axi_slave;
  import core_timer_axi_slave_pkg::*;

  localparam int AW = 16;

  logic              ACLK, ARESET;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]       AWADDR, ARADDR, WDATA, RDATA, write_data, read_data;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              valid_reg_write, valid_reg_read, read_data_valid;
  logic [AW-1:0]     addr;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [31:0] data; } stb_t;
  typedef struct { bit rd; logic [1:0] resp; logic [31:0] data; } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  stb_t mon_s;
  rsp_t mon_r;
  int   vecs = 0;
  int   miss = 0;
  bit   ar_blocked = 0;

  core_timer_axi_slave #(.ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .valid_reg_write(valid_reg_write), .valid_reg_read(valid_reg_read),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .read_data_valid(read_data_valid)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: strobes and response handshakes must match the queued expectations.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (valid_reg_write || valid_reg_read) begin
        vecs++;
        assert (stb_q.size() != 0) else begin
          miss++;
          $error("FAIL unexp_strobe: observed wr=%0b rd=%0b expected none", valid_reg_write, valid_reg_read);
        end
        if (stb_q.size() != 0) begin
          mon_s = stb_q.pop_front();
          chk("stb_kind", {valid_reg_write, valid_reg_read}, {mon_s.wr, !mon_s.wr});
          chk("stb_addr", addr, mon_s.addr);
          if (mon_s.wr) chk("stb_wdata", write_data, mon_s.data);
        end
      end
      if ((BVALID && BREADY) || (RVALID && RREADY)) begin
        vecs++;
        assert (rsp_q.size() != 0) else begin
          miss++;
          $error("FAIL unexp_resp: observed b=%0b r=%0b expected none", BVALID, RVALID);
        end
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chk("rsp_kind", RVALID, mon_r.rd);
          if (mon_r.rd) begin
            chk("rresp", RRESP, mon_r.resp);
            chk("rdata", RDATA, mon_r.data);
          end else chk("bresp", BRESP, mon_r.resp);
        end
      end
      if (ar_blocked) chk("ar_blocked", ARREADY, 1'b0);
    end
  end

  task automatic wait_valid(input bit rd);
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!(rd ? RVALID : BVALID) && n < 8);
    chk(rd ? "r_latency" : "b_latency", n, 2);
  endtask

  task automatic push_rd(input logic [31:0] a);
    bit ok = (a[1:0] == 2'b00);
    bit good = ok && read_data_valid;
    if (ok) stb_q.push_back('{wr: 1'b0, addr: a[AW-1:0], data: 32'h0});
    rsp_q.push_back('{rd: 1'b1, resp: good ? RESP_OKAY : RESP_SLVERR, data: good ? read_data : 32'h0});
  endtask

  task automatic axi_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, input bit ar_blk);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs, err;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == aw_at) begin AWVALID = 1; AWADDR = a; end
      if (c == w_at)  begin WVALID = 1; WDATA = d; WSTRB = s; end
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin AWVALID = 0; aw_done = 1; end
      if (w_hs)  begin WVALID = 0; w_done = 1; end
      if (ar_blk && w_done && !ARVALID) begin
        ARVALID = 1; ARADDR = MTIME_ADDR; ar_blocked = 1;
      end
    end
    AWVALID = 0; WVALID = 0;
    chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
    err = (a[1:0] != 2'b00) || (s != 4'hF);
    if (!err) stb_q.push_back('{wr: 1'b1, addr: a[AW-1:0], data: d});
    rsp_q.push_back('{rd: 1'b0, resp: err ? RESP_SLVERR : RESP_OKAY, data: 32'h0});
    wait_valid(1'b0);
  endtask

  task automatic b_resp(input int stall);
    logic [1:0] r0 = BRESP;
    for (int i = 0; i < stall; i++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("b_hold_valid", BVALID, 1'b1);
      chk("b_hold_resp", BRESP, r0);
    end
    @(posedge ACLK); #1; BREADY = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1; BREADY = 0; ar_blocked = 0;
    @(negedge ACLK);
    chk("b_drop", BVALID, 1'b0);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_ar(input logic [31:0] a);
    bit done = 0;
    bit hs;
    ARVALID = 1; ARADDR = a;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge ACLK);
      hs = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin ARVALID = 0; done = 1; end
    end
    ARVALID = 0;
    chk("ar_handshake", done, 1'b1);
    push_rd(a);
    wait_valid(1'b1);
  endtask

  task automatic r_resp(input int stall);
    logic [1:0]  r0 = RRESP;
    logic [31:0] d0 = RDATA;
    for (int i = 0; i < stall; i++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("r_hold_valid", RVALID, 1'b1);
      chk("r_hold_resp", RRESP, r0);
      chk("r_hold_data", RDATA, d0);
    end
    @(posedge ACLK); #1; RREADY = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1; RREADY = 0;
    @(negedge ACLK);
    chk("r_drop", RVALID, 1'b0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESET = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; read_data = 0; read_data_valid = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID}, 2'b00);
    chk("rst_resp", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_strobe", {valid_reg_write, valid_reg_read}, 2'b00);
    chk("rst_addr_wdata", {addr, write_data}, 48'h0);
    @(posedge ACLK); #1; ARESET = 0;
    @(negedge ACLK);
    chk("idle_aw_ready", {AWREADY, WREADY, ARREADY}, 3'b110);
    @(posedge ACLK); #1;

    // AW and W together, BREADY already high
    BREADY = 1;
    axi_aw_w(32'h0000_4000, 32'h0000_0010, 4'hF, 0, 0, 0);
    b_resp(0);

    // upper address bits ignored, master stalls B for 3 cycles
    axi_aw_w(32'hDEAD_4004, 32'hCAFE_BABE, 4'hF, 0, 0, 0);
    b_resp(3);

    // W leads AW by 3 cycles; a read raised meanwhile waits for the B handshake
    read_data = 32'h1234_ABCD; read_data_valid = 1;
    axi_aw_w(MTIMECMP_ADDR, 32'h0000_0055, 4'hF, 3, 0, 1);
    push_rd(MTIME_ADDR);
    b_resp(0);
    ARVALID = 0;
    wait_valid(1'b1);
    r_resp(0);

    // AW leads W
    axi_aw_w(32'h0000_4008, 32'h0BAD_CAFE, 4'hF, 0, 2, 0);
    b_resp(1);

    // read with RREADY held low 4 cycles
    read_data = 32'h1234_5678;
    axi_ar(32'h0000_BFF8);
    r_resp(4);

    // error cases
    axi_aw_w(32'h0000_4002, 32'h1111_1111, 4'hF, 0, 0, 0);
    b_resp(0);
    axi_aw_w(32'h0000_4000, 32'h2222_2222, 4'h3, 0, 0, 0);
    b_resp(0);
    axi_ar(32'h0000_4001);
    r_resp(0);
    read_data_valid = 0;
    axi_ar(32'h0000_4000);
    r_resp(0);

    // round-robin: all requests held high after a fresh reset
    @(posedge ACLK); #1; ARESET = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1; ARESET = 0;
    AWADDR = 32'h0000_4010; WDATA = 32'hA5A5_0001; WSTRB = 4'hF; ARADDR = 32'h0000_4018;
    read_data = 32'h0BAD_F00D; read_data_valid = 1; BREADY = 1; RREADY = 1;
    for (int i = 0; i < 2; i++) begin
      stb_q.push_back('{wr: 1'b1, addr: 16'h4010, data: 32'hA5A5_0001});
      stb_q.push_back('{wr: 1'b0, addr: 16'h4018, data: 32'h0});
      rsp_q.push_back('{rd: 1'b0, resp: RESP_OKAY, data: 32'h0});
      rsp_q.push_back('{rd: 1'b1, resp: RESP_OKAY, data: 32'h0BAD_F00D});
    end
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    n = 0;
    do begin @(posedge ACLK); #1; n++; end while ((stb_q.size() != 0 || rsp_q.size() != 0) && n < 60);
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    chk("arb_rsp_drained", rsp_q.size(), 0);
    chk("arb_stb_drained", stb_q.size(), 0);

    // reset during WR_RESP abandons the write
    axi_aw_w(32'h0000_4008, 32'h0000_0077, 4'hF, 0, 0, 0);
    @(posedge ACLK); #1; ARESET = 1;
    @(negedge ACLK);
    chk("midrst_bvalid", BVALID, 1'b0);
    chk("midrst_addr_wdata", {addr, write_data}, 48'h0);
    chk("midrst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    rsp_q.delete();
    @(posedge ACLK); #1; ARESET = 0; BREADY = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("postrst_idle", {AWREADY, WREADY, BVALID}, 3'b110);
      @(posedge ACLK); #1;
    end
    BREADY = 0;

    chk("final_stb_empty", stb_q.size(), 0);
    chk("final_rsp_empty", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
